// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : wb_port_arbiter_if
// Brief  : Requester-side and register-file write-side bundle of the arbiter.
// Rev    : 1.0
// ============================================================================
interface wb_port_arbiter_if #(
    parameter int WIDTH = 5,
    parameter int NREQ  = 6
);
    logic [NREQ-1:0]       i_valid;
    logic [NREQ-1:0]       o_ready;
    logic [NREQ*WIDTH-1:0] i_waddr;
    logic [NREQ*32-1:0]    i_wdata;

    logic                  o_we0, o_we1, o_we2, o_we3;
    logic [WIDTH-1:0]      o_waddr0, o_waddr1, o_waddr2, o_waddr3;
    logic [31:0]           o_wdata0, o_wdata1, o_wdata2, o_wdata3;

    modport master (
        input  i_valid, i_waddr, i_wdata,
        output o_ready,
        output o_we0, o_we1, o_we2, o_we3,
        output o_waddr0, o_waddr1, o_waddr2, o_waddr3,
        output o_wdata0, o_wdata1, o_wdata2, o_wdata3
    );

    modport slave (
        output i_valid, i_waddr, i_wdata,
        input  o_ready,
        input  o_we0, o_we1, o_we2, o_we3,
        input  o_waddr0, o_waddr1, o_waddr2, o_waddr3,
        input  o_wdata0, o_wdata1, o_wdata2, o_wdata3
    );
endinterface
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : wb_port_arbiter
// Brief  : Round-robin writeback arbiter, NREQ requesters onto 4 RF write ports.
//          Optional statistics counters under macro WBARB_STATS_EN.
// Rev    : 1.0
// ============================================================================
module wb_port_arbiter #(
    parameter int WIDTH = 5,
    parameter int NREQ  = 6
) (
    input  wire logic        i_clk,
    input  wire logic        i_rst_n,
    wb_port_arbiter_if.master bus
`ifdef WBARB_STATS_EN
    ,
    output logic [31:0]      o_grant_cnt,
    output logic [31:0]      o_stall_cnt
`endif
);
    localparam int c_NPORT = 4;
    localparam int c_IW    = $clog2(NREQ);

    function automatic logic [c_IW-1:0] f_wrap_inc(input logic [c_IW-1:0] a);
        return (a == c_IW'(NREQ-1)) ? '0 : a + c_IW'(1);
    endfunction

    logic [c_IW-1:0]   r_ptr;
    logic [c_NPORT-1:0] r_we;
    logic [WIDTH-1:0]  r_waddr [c_NPORT];
    logic [31:0]       r_wdata [c_NPORT];

    logic [NREQ-1:0]   w_ready;
    logic              w_pvld  [c_NPORT];
    logic [WIDTH-1:0]  w_paddr [c_NPORT];
    logic [31:0]       w_pdata [c_NPORT];
    logic [2:0]        w_ngrant;
    logic [c_IW-1:0]   w_last;
    logic [c_IW-1:0]   w_scan;
    logic [WIDTH-1:0]  w_addr_k;
    logic              w_hit;
    logic              w_stall;

    // Scan from r_ptr; ports fill in scan order, duplicates of an already
    // granted address are skipped without blocking later requesters.
    always_comb begin
        w_ready  = '0;
        w_ngrant = '0;
        w_last   = r_ptr;
        w_scan   = r_ptr;
        w_stall  = 1'b0;
        w_addr_k = '0;
        w_hit    = 1'b0;
        for (int p = 0; p < c_NPORT; p++) begin
            w_pvld[p]  = 1'b0;
            w_paddr[p] = '0;
            w_pdata[p] = '0;
        end
        for (int i = 0; i < NREQ; i++) begin
            w_addr_k = bus.i_waddr[w_scan*WIDTH +: WIDTH];
            w_hit    = 1'b0;
            for (int p = 0; p < c_NPORT; p++) begin
                if (w_pvld[p] && (w_paddr[p] == w_addr_k)) begin
                    w_hit = 1'b1;
                end
            end
            if (bus.i_valid[w_scan]) begin
                if (w_addr_k == '0) begin
                    w_ready[w_scan] = 1'b1;
                end else if (!w_hit && (w_ngrant < 3'd4)) begin
                    w_ready[w_scan]          = 1'b1;
                    w_pvld[w_ngrant[1:0]]    = 1'b1;
                    w_paddr[w_ngrant[1:0]]   = w_addr_k;
                    w_pdata[w_ngrant[1:0]]   = bus.i_wdata[w_scan*32 +: 32];
                    w_ngrant                 = w_ngrant + 3'd1;
                    w_last                   = w_scan;
                end else begin
                    w_stall = 1'b1;
                end
            end
            w_scan = f_wrap_inc(w_scan);
        end
    end

    assign bus.o_ready = w_ready & {NREQ{i_rst_n}};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
            r_we  <= '0;
            for (int p = 0; p < c_NPORT; p++) begin
                r_waddr[p] <= '0;
                r_wdata[p] <= '0;
            end
        end else begin
            if (w_ngrant != 3'd0) begin
                r_ptr <= f_wrap_inc(w_last);
            end
            for (int p = 0; p < c_NPORT; p++) begin
                r_we[p] <= w_pvld[p];
                if (w_pvld[p]) begin
                    r_waddr[p] <= w_paddr[p];
                    r_wdata[p] <= w_pdata[p];
                end
            end
        end
    end

    assign bus.o_we0    = r_we[0];
    assign bus.o_we1    = r_we[1];
    assign bus.o_we2    = r_we[2];
    assign bus.o_we3    = r_we[3];
    assign bus.o_waddr0 = r_waddr[0];
    assign bus.o_waddr1 = r_waddr[1];
    assign bus.o_waddr2 = r_waddr[2];
    assign bus.o_waddr3 = r_waddr[3];
    assign bus.o_wdata0 = r_wdata[0];
    assign bus.o_wdata1 = r_wdata[1];
    assign bus.o_wdata2 = r_wdata[2];
    assign bus.o_wdata3 = r_wdata[3];

`ifdef WBARB_STATS_EN
    logic [31:0] r_grant_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_grant_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_grant_cnt <= r_grant_cnt + 32'(w_ngrant);
            r_stall_cnt <= r_stall_cnt + 32'(w_stall);
        end
    end

    assign o_grant_cnt = r_grant_cnt;
    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire
